// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game controller: state codes,
// parameter defaults and a saturating score helper.
package breakout_pkg;

  localparam int LIVES_INIT_DEF   = 3;
  localparam int DEB_FRAMES_DEF   = 2;
  localparam int LOST_FRAMES_DEF  = 60;
  localparam int FLASH_FRAMES_DEF = 16;
  localparam int STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_LOST  = 3'd3,
    ST_OVER  = 3'd4,
    ST_WIN   = 3'd5
  } state_e;

  // Score never wraps: it sticks at the top value.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/breakout_game_ctrl_if.sv
// Signal bundle between the game datapath (master) and the controller (slave).
// Handshake semantics: there is no ready/back-pressure anywhere. Pulse signals
// (frame_tick, brick_hit, ball_lost, clear_field, serve_req) are valid for
// exactly one clock and are consumed in that cycle; serve_dir is valid only
// while serve_req is high; all other signals are levels sampled every clock.
interface breakout_game_ctrl_if;
  import breakout_pkg::*;

  // datapath -> controller
  logic               frame_tick;
  logic               left_n;
  logic               right_n;
  logic               fire1_n;
  logic               fire2_n;
  logic               brick_hit;
  logic               ball_lost;
  logic               bricks_empty;
  // controller -> datapath
  logic [STATE_W-1:0] state;
  logic               clear_field;
  logic               serve_req;
  logic               serve_dir;
  logic               move_left;
  logic               move_right;
  logic [1:0]         lives;
  logic [15:0]        score;
  logic               flash;

  modport master (
    output frame_tick, left_n, right_n, fire1_n, fire2_n,
           brick_hit, ball_lost, bricks_empty,
    input  state, clear_field, serve_req, serve_dir,
           move_left, move_right, lives, score, flash
  );

  modport slave (
    input  frame_tick, left_n, right_n, fire1_n, fire2_n,
           brick_hit, ball_lost, bricks_empty,
    output state, clear_field, serve_req, serve_dir,
           move_left, move_right, lives, score, flash
  );

endinterface

// File: rtl/breakout_game_ctrl_btn_debounce.sv
// One button: 2-flop synchronizer, frame-rate debounce, and a one-cycle
// press pulse on the debounced 1->0 (release->pressed) edge.
module btn_debounce
  import breakout_pkg::*;
#(
  parameter int DEB_FRAMES = DEB_FRAMES_DEF
) (
  input  logic clock,
  input  logic rst_n,
  input  logic frame_tick_i,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = (DEB_FRAMES < 2) ? 1 : $clog2(DEB_FRAMES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count frame samples that disagree with the accepted level; accept after
  // DEB_FRAMES in a row, any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (frame_tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEB_FRAMES - 1)) begin
        level_d = sync2_q;
        cnt_d   = '0;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer and debounce state; released (1) out of reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

// File: rtl/breakout_game_ctrl.sv
// Breakout game flow controller: buttons -> game FSM -> registered commands,
// lives, score and the end-of-game flash.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int DEB_FRAMES   = DEB_FRAMES_DEF,
  parameter int LOST_FRAMES  = LOST_FRAMES_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic                 clock,
  input  logic                 rst_n,
  breakout_game_ctrl_if.slave  ctrl_if
);

  localparam int LW = $clog2(LOST_FRAMES + 1);
  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic left_lvl, left_prs, right_lvl, right_prs;
  logic f1_lvl, f1_prs, f2_lvl, f2_prs;

  logic [STATE_W-1:0] state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [15:0]        score_q, score_d;
  logic [LW-1:0]      lost_cnt_q, lost_cnt_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  logic               flash_q, flash_d;
  logic               clear_q, clear_d;
  logic               serve_q, serve_d;
  logic               dir_q, dir_d;
  logic               mleft_q, mleft_d;
  logic               mright_q, mright_d;
  logic               lost_done;
  logic               in_end_q, in_end_d;
  logic               unused_ok;

  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_left (
    .clock(clock), .rst_n(rst_n), .frame_tick_i(ctrl_if.frame_tick),
    .btn_n_i(ctrl_if.left_n), .level_o(left_lvl), .press_o(left_prs));
  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_right (
    .clock(clock), .rst_n(rst_n), .frame_tick_i(ctrl_if.frame_tick),
    .btn_n_i(ctrl_if.right_n), .level_o(right_lvl), .press_o(right_prs));
  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_fire1 (
    .clock(clock), .rst_n(rst_n), .frame_tick_i(ctrl_if.frame_tick),
    .btn_n_i(ctrl_if.fire1_n), .level_o(f1_lvl), .press_o(f1_prs));
  btn_debounce #(.DEB_FRAMES(DEB_FRAMES)) u_fire2 (
    .clock(clock), .rst_n(rst_n), .frame_tick_i(ctrl_if.frame_tick),
    .btn_n_i(ctrl_if.fire2_n), .level_o(f2_lvl), .press_o(f2_prs));

  // Right press and fire levels have no role in the game flow.
  assign unused_ok = &{1'b0, right_prs, f1_lvl, f2_lvl};

  assign lost_done = (state_q == ST_LOST) && ctrl_if.frame_tick &&
                     (lost_cnt_q == LW'(LOST_FRAMES - 1));
  assign in_end_q  = (state_q == ST_WIN) || (state_q == ST_OVER);
  assign in_end_d  = (state_d == ST_WIN) || (state_d == ST_OVER);

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; win beats a simultaneous ball loss, fire1 beats fire2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (left_prs) state_d = ST_SERVE;
      ST_SERVE: if (f1_prs || f2_prs) state_d = ST_PLAY;
      ST_PLAY: begin
        if (ctrl_if.bricks_empty)   state_d = ST_WIN;
        else if (ctrl_if.ball_lost) state_d = ST_LOST;
      end
      ST_LOST:  if (lost_done) state_d = (lives_q != 2'd0) ? ST_SERVE : ST_OVER;
      ST_OVER,
      ST_WIN:   if (f1_prs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, timers and game counters.
  always_comb begin
    lives_d     = lives_q;
    score_d     = score_q;
    clear_d     = 1'b0;
    serve_d     = 1'b0;
    dir_d       = 1'b0;
    lost_cnt_d  = '0;
    flash_d     = 1'b0;
    flash_cnt_d = '0;
    mleft_d     = 1'b0;
    mright_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (left_prs) begin
          clear_d = 1'b1;
          lives_d = 2'(LIVES_INIT);
          score_d = '0;
        end
      end
      ST_SERVE: begin
        if (f1_prs || f2_prs) begin
          serve_d = 1'b1;
          dir_d   = f1_prs;
        end
      end
      ST_PLAY: begin
        if (ctrl_if.brick_hit) score_d = sat_inc16(score_q);
        if (!ctrl_if.bricks_empty && ctrl_if.ball_lost && (lives_q != 2'd0))
          lives_d = lives_q - 2'd1;
      end
      ST_LOST: begin
        lost_cnt_d = lost_cnt_q;
        if (ctrl_if.frame_tick)
          lost_cnt_d = lost_done ? '0 : lost_cnt_q + LW'(1);
        clear_d = lost_done && (lives_q != 2'd0);
      end
      default: ;
    endcase
    // Flash runs only while staying in WIN/OVER, so it drops with the state.
    if (in_end_q && in_end_d) begin
      flash_d     = flash_q;
      flash_cnt_d = flash_cnt_q;
      if (ctrl_if.frame_tick) begin
        if (flash_cnt_q == FW'(FLASH_FRAMES - 1)) begin
          flash_d     = ~flash_q;
          flash_cnt_d = '0;
        end else begin
          flash_cnt_d = flash_cnt_q + FW'(1);
        end
      end
    end
    if ((state_d == ST_SERVE) || (state_d == ST_PLAY)) begin
      mleft_d  = ~left_lvl;
      mright_d = ~right_lvl & left_lvl;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      lives_q     <= 2'd0;
      score_q     <= 16'd0;
      lost_cnt_q  <= '0;
      flash_cnt_q <= '0;
      flash_q     <= 1'b0;
      clear_q     <= 1'b0;
      serve_q     <= 1'b0;
      dir_q       <= 1'b0;
      mleft_q     <= 1'b0;
      mright_q    <= 1'b0;
    end else begin
      lives_q     <= lives_d;
      score_q     <= score_d;
      lost_cnt_q  <= lost_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      flash_q     <= flash_d;
      clear_q     <= clear_d;
      serve_q     <= serve_d;
      dir_q       <= dir_d;
      mleft_q     <= mleft_d;
      mright_q    <= mright_d;
    end
  end

  assign ctrl_if.state       = state_q;
  assign ctrl_if.lives       = lives_q;
  assign ctrl_if.score       = score_q;
  assign ctrl_if.flash       = flash_q;
  assign ctrl_if.clear_field = clear_q;
  assign ctrl_if.serve_req   = serve_q;
  assign ctrl_if.serve_dir   = dir_q;
  assign ctrl_if.move_left   = mleft_q;
  assign ctrl_if.move_right  = mright_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed bench for breakout_game_ctrl: pulse events (clear_field /
// serve_req) are scoreboarded, levels are checked at fixed points.
module tb_breakout_game_ctrl;
  import breakout_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  breakout_game_ctrl_if bus();

  breakout_game_ctrl #(
    .LIVES_INIT(3), .DEB_FRAMES(2), .LOST_FRAMES(60), .FLASH_FRAMES(16)
  ) dut (
    .clock(clock), .rst_n(rst_n), .ctrl_if(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  // event word: {clear_field, serve_req, serve_dir, state[2:0], lives[1:0], score[15:0]}
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  logic        saw_mright = 1'b0;

  function automatic logic [23:0] ev(input logic c, input logic s, input logic d,
                                     input logic [2:0] st, input logic [1:0] lv,
                                     input logic [15:0] sc);
    return {c, s, d, st, lv, sc};
  endfunction

  always @(negedge clock) begin
    if (bus.clear_field === 1'b1 || bus.serve_req === 1'b1)
      obs_q.push_back(ev(bus.clear_field, bus.serve_req, bus.serve_dir,
                         bus.state, bus.lives, bus.score));
    if (bus.move_right === 1'b1) saw_mright = 1'b1;
  end

  // ---------------- driver / check tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      cyc(3);
      bus.frame_tick = 1'b1;
      cyc(1);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [23:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input string tag);
    int waited;
    logic [23:0] e;
    logic [23:0] o;
    waited = 0;
    while (obs_q.size() == 0 && waited < 200) begin
      @(negedge clock);
      #1;
      waited++;
    end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed no event expected %06h", tag, e);
    end else begin
      o = obs_q.pop_front();
      check(tag, 32'(o), 32'(e));
    end
  endtask

  task automatic sb_quiet(input string tag);
    #1;
    check(tag, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
  endtask

  task automatic pulse_hits(input int n);
    repeat (n) begin
      bus.brick_hit = 1'b1;
      cyc(1);
      bus.brick_hit = 1'b0;
      cyc(1);
    end
  endtask

  task automatic lose_ball();
    bus.ball_lost = 1'b1;
    cyc(1);
    bus.ball_lost = 1'b0;
    cyc(1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bus.frame_tick   = 1'b0;
    bus.left_n       = 1'b1;
    bus.right_n      = 1'b1;
    bus.fire1_n      = 1'b1;
    bus.fire2_n      = 1'b1;
    bus.brick_hit    = 1'b0;
    bus.ball_lost    = 1'b0;
    bus.bricks_empty = 1'b0;

    // reset values
    cyc(3);
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_lives", 32'(bus.lives), 32'd0);
    check("rst_score", 32'(bus.score), 32'd0);
    check("rst_flash", 32'(bus.flash), 32'd0);
    check("rst_clear", 32'(bus.clear_field), 32'd0);
    check("rst_serve", 32'(bus.serve_req), 32'd0);
    check("rst_mleft", 32'(bus.move_left), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // game start by left press
    sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 16'd0));
    bus.left_n = 1'b0;
    frames(3);
    sb_pop("start");
    check("start_state", 32'(bus.state), 32'd1);
    check("mleft_held", 32'(bus.move_left), 32'd1);
    bus.left_n = 1'b1;
    frames(3);
    check("mleft_released", 32'(bus.move_left), 32'd0);

    // both fire buttons together: fire1 wins, single serve
    sb_push(ev(1'b0, 1'b1, 1'b1, 3'd2, 2'd3, 16'd0));
    bus.fire1_n = 1'b0;
    bus.fire2_n = 1'b0;
    frames(3);
    sb_pop("serve_both");
    check("play_state", 32'(bus.state), 32'd2);
    bus.fire1_n = 1'b1;
    bus.fire2_n = 1'b1;
    frames(3);
    sb_quiet("serve_single");

    // five bricks then a lost ball
    pulse_hits(5);
    lose_ball();
    check("lost_score", 32'(bus.score), 32'd5);
    check("lost_lives", 32'(bus.lives), 32'd2);
    check("lost_state", 32'(bus.state), 32'd3);
    frames(59);
    check("lost_hold59", 32'(bus.state), 32'd3);
    sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'd2, 16'd5));
    frames(1);
    sb_pop("lost_reserve");

    // one-frame glitch on right must not move the paddle
    saw_mright = 1'b0;
    bus.right_n = 1'b0;
    frames(1);
    bus.right_n = 1'b1;
    frames(3);
    check("right_glitch", 32'(saw_mright), 32'd0);
    bus.right_n = 1'b0;
    frames(3);
    check("mright_held", 32'(bus.move_right), 32'd1);
    bus.left_n = 1'b0;
    frames(3);
    check("prio_mright", 32'(bus.move_right), 32'd0);
    check("prio_mleft", 32'(bus.move_left), 32'd1);
    bus.left_n  = 1'b1;
    bus.right_n = 1'b1;
    frames(3);
    sb_quiet("no_serve_on_moves");

    // serve to the right with fire2
    sb_push(ev(1'b0, 1'b1, 1'b0, 3'd2, 2'd2, 16'd5));
    bus.fire2_n = 1'b0;
    frames(3);
    sb_pop("serve_fire2");
    bus.fire2_n = 1'b1;
    frames(3);

    // win and loss in the same cycle, plus a brick that is still scored
    bus.brick_hit    = 1'b1;
    bus.bricks_empty = 1'b1;
    bus.ball_lost    = 1'b1;
    cyc(1);
    bus.brick_hit    = 1'b0;
    bus.bricks_empty = 1'b0;
    bus.ball_lost    = 1'b0;
    check("win_state", 32'(bus.state), 32'd5);
    check("win_lives", 32'(bus.lives), 32'd2);
    check("win_score", 32'(bus.score), 32'd6);
    pulse_hits(1);
    check("win_hit_ignored", 32'(bus.score), 32'd6);
    frames(15);
    check("flash_15", 32'(bus.flash), 32'd0);
    frames(1);
    check("flash_16", 32'(bus.flash), 32'd1);
    frames(15);
    check("flash_31", 32'(bus.flash), 32'd1);
    frames(1);
    check("flash_32", 32'(bus.flash), 32'd0);
    bus.fire1_n = 1'b0;
    frames(3);
    check("win_exit_state", 32'(bus.state), 32'd0);
    check("win_exit_lives", 32'(bus.lives), 32'd2);
    check("win_exit_score", 32'(bus.score), 32'd6);
    bus.fire1_n = 1'b1;
    frames(3);

    // second game: lose all lives
    sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 16'd0));
    bus.left_n = 1'b0;
    frames(3);
    sb_pop("start2");
    bus.left_n = 1'b1;
    frames(3);
    for (int i = 0; i < 3; i++) begin
      sb_push(ev(1'b0, 1'b1, 1'b1, 3'd2, 2'(3 - i), 16'd0));
      bus.fire1_n = 1'b0;
      frames(3);
      sb_pop("serve_round");
      bus.fire1_n = 1'b1;
      frames(3);
      lose_ball();
      check("round_lives", 32'(bus.lives), 32'(2 - i));
      check("round_lost", 32'(bus.state), 32'd3);
      if (i < 2) begin
        sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'(2 - i), 16'd0));
        frames(60);
        sb_pop("round_reserve");
      end else begin
        frames(60);
        check("over_state", 32'(bus.state), 32'd4);
        sb_quiet("over_no_clear");
      end
    end
    frames(15);
    check("over_flash_15", 32'(bus.flash), 32'd0);
    frames(1);
    check("over_flash_16", 32'(bus.flash), 32'd1);
    bus.fire1_n = 1'b0;
    frames(3);
    check("over_exit_state", 32'(bus.state), 32'd0);
    check("over_exit_flash", 32'(bus.flash), 32'd0);
    bus.fire1_n = 1'b1;
    frames(3);

    // third game: reset in the middle of play
    sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 16'd0));
    bus.left_n = 1'b0;
    frames(3);
    sb_pop("start3");
    bus.left_n = 1'b1;
    frames(3);
    sb_push(ev(1'b0, 1'b1, 1'b0, 3'd2, 2'd3, 16'd0));
    bus.fire2_n = 1'b0;
    frames(3);
    sb_pop("serve3");
    bus.fire2_n = 1'b1;
    frames(3);
    pulse_hits(2);
    check("score3", 32'(bus.score), 32'd2);
    bus.right_n = 1'b0;
    frames(3);
    check("mright3", 32'(bus.move_right), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(bus.state), 32'd0);
    check("midrst_lives", 32'(bus.lives), 32'd0);
    check("midrst_score", 32'(bus.score), 32'd0);
    check("midrst_mright", 32'(bus.move_right), 32'd0);
    check("midrst_clear", 32'(bus.clear_field), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    bus.right_n = 1'b1;
    frames(4);
    sb_quiet("midrst_no_clear");
    check("midrst_idle", 32'(bus.state), 32'd0);
    sb_push(ev(1'b1, 1'b0, 1'b0, 3'd1, 2'd3, 16'd0));
    bus.left_n = 1'b0;
    frames(3);
    sb_pop("restart");
    bus.left_n = 1'b1;
    frames(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
